// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution with programmable kernel, shift and clamp
// Optional feature macro: CONV_ABS_EN (clamp stage takes |result| before saturating)
module conv3x3_stream #(
   parameter int WORD_SIZE    = 8,
   parameter int ROW_SIZE     = 540,
   parameter int IMAGE_HEIGHT = 360,
   parameter int COEF_SIZE    = 8,
   parameter int SHIFT        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] inputPixel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 coef_load,
   input  logic [3:0]           coef_idx,
   input  logic [COEF_SIZE-1:0] coef_data,
   output logic [WORD_SIZE-1:0] outputPixel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_done
);

   localparam int SUM_W = WORD_SIZE + COEF_SIZE + 5;
   localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam logic signed [SUM_W-1:0] MAX_PIX = SUM_W'((1 << WORD_SIZE) - 1);
   localparam logic signed [COEF_SIZE-1:0] COEF_ONE = COEF_SIZE'(1 << SHIFT);

   // Position of the next pixel to be accepted
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   // Line buffers: lb0 holds row r-1, lb1 holds row r-2, indexed by column
   logic [WORD_SIZE-1:0] lb0_q [ROW_SIZE];
   logic [WORD_SIZE-1:0] lb1_q [ROW_SIZE];

   // 3x3 window: [row][col], row 0 = oldest line, col 2 = newest column
   logic [WORD_SIZE-1:0] win_q [3][3];
   logic [WORD_SIZE-1:0] win_d [3][3];

   logic signed [COEF_SIZE-1:0] coef_q [9];

   logic                 out_valid_q;
   logic [WORD_SIZE-1:0] out_pix_q;
   logic                 frame_done_q;

   logic accept, produce, col_last, row_last, idle;
   logic signed [SUM_W-1:0] prod [9];
   logic signed [SUM_W-1:0] sum_d, res_d;
   logic [WORD_SIZE-1:0]    pix_res_d;

   assign in_ready    = !out_valid_q || out_ready;
   assign accept      = in_valid && in_ready;
   assign col_last    = (col_q == COL_W'(ROW_SIZE - 1));
   assign row_last    = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
   assign produce     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
   assign idle        = (row_q == '0) && (col_q == '0) && !out_valid_q;

   assign outputPixel = out_pix_q;
   assign out_valid   = out_valid_q;
   assign frame_done  = frame_done_q;

   // Raster position advance on each accepted pixel
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // Window as it will look once the current pixel is accepted
   always_comb begin
      win_d = win_q;
      for (int i = 0; i < 3; i++) begin
         win_d[i][0] = win_q[i][1];
         win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = inputPixel;
   end

   for (genvar k = 0; k < 9; k++) begin : g_mac
      assign prod[k] = SUM_W'(coef_q[k]) * $signed(SUM_W'({1'b0, win_d[k/3][k%3]}));
   end

   // Accumulate, normalise and saturate to the pixel range
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < 9; k++) begin
         sum_d = sum_d + prod[k];
      end
      res_d = sum_d >>> SHIFT;
`ifdef CONV_ABS_EN
      if (res_d[SUM_W-1]) begin
         res_d = -res_d;
      end
`endif
      if (res_d[SUM_W-1]) begin
         pix_res_d = '0;
      end else if (res_d > MAX_PIX) begin
         pix_res_d = '1;
      end else begin
         pix_res_d = res_d[WORD_SIZE-1:0];
      end
   end

   // Position counters
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Line buffers and window shift; contents need no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[col_q] <= inputPixel;
         lb1_q[col_q] <= lb0_q[col_q];
         win_q        <= win_d;
      end
   end

   // Kernel storage; writes only land between frames
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 9; k++) begin
            coef_q[k] <= '0;
         end
         coef_q[4] <= COEF_ONE;
      end else if (coef_load && idle && (coef_idx <= 4'd8)) begin
         coef_q[coef_idx] <= coef_data;
      end
   end

   // Single output register with hold-until-ready and end-of-frame pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_pix_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= accept && col_last && row_last;
         if (produce) begin
            out_valid_q <= 1'b1;
            out_pix_q   <= pix_res_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule
